// File: rtl/pipe_ctrl_pkg.sv
// Shared types and the RUN-state priority decision for the 3-stage pipeline controller.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_RUN   = 3'd1,
    ST_MWAIT = 3'd2,
    ST_MCYC  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic fd_flush;
    logic dw_en;
    logic dw_flush;
  } ctrl_t;

  typedef struct packed {
    ctrl_t  ctrl;
    state_t next;
    logic   load_cnt;
  } decision_t;

  localparam ctrl_t CTRL_FREEZE = 5'b00000;
  localparam ctrl_t CTRL_RUN    = 5'b11010;
  localparam ctrl_t CTRL_BUBBLE = 5'b00011;
  localparam ctrl_t CTRL_TRAP   = 5'b11111;
  localparam ctrl_t CTRL_REDIR  = 5'b11110;
  localparam ctrl_t CTRL_NOFET  = 5'b01110;

  // mask_mem / mask_mc suppress the memory-wait and multi-cycle terms when
  // resuming from MWAIT or MCYC; flush_multi is 0 when a redirect costs one bubble.
  function automatic decision_t run_decision(
    input logic trap,
    input logic redirect,
    input logic dmem_req,
    input logic dmem_ready,
    input logic mc_start,
    input logic ld_use,
    input logic if_valid,
    input logic halt_req,
    input logic mask_mem,
    input logic mask_mc,
    input logic flush_multi
  );
    decision_t d;
    d.ctrl     = CTRL_RUN;
    d.next     = ST_RUN;
    d.load_cnt = 1'b0;
    if (trap) begin
      d.ctrl     = CTRL_TRAP;
      d.load_cnt = 1'b1;
      d.next     = flush_multi ? ST_FLUSH : ST_RUN;
    end else if (redirect) begin
      d.ctrl     = CTRL_REDIR;
      d.load_cnt = 1'b1;
      d.next     = flush_multi ? ST_FLUSH : ST_RUN;
    end else if (!mask_mem && dmem_req && !dmem_ready) begin
      d.ctrl = CTRL_FREEZE;
      d.next = ST_MWAIT;
    end else if (!mask_mc && mc_start) begin
      d.ctrl = CTRL_BUBBLE;
      d.next = ST_MCYC;
    end else if (ld_use) begin
      d.ctrl = CTRL_BUBBLE;
    end else if (!if_valid) begin
      d.ctrl = CTRL_NOFET;
    end else if (halt_req) begin
      d.ctrl = CTRL_FREEZE;
      d.next = ST_HALT;
    end else begin
      d.ctrl = CTRL_RUN;
    end
    return d;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  output logic [CNTW-1:0] count
);

  logic [CNTW-1:0] count_r;

  // count register with saturation at the maximum value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (inc && (count_r != {CNTW{1'b1}})) begin
      count_r <= count_r + CNTW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: Mealy enables/NOP selects for PC, F->D and D->W banks,
// with stall, flush and debug-halt handling plus a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC = 1,
  parameter int CNTW      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic            ld_use,
  input  logic            mc_start,
  input  logic            mc_done,
  input  logic            dmem_req,
  input  logic            dmem_ready,
  input  logic            redirect,
  input  logic            trap,
  input  logic            halt_req,
  output logic            pc_en,
  output logic            fd_en,
  output logic            fd_flush,
  output logic            dw_en,
  output logic            dw_flush,
  output logic            halted,
  output logic [CNTW-1:0] stall_cnt,
  output logic [2:0]      state
);

  localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYC - 1);
  localparam logic       FLUSH_MULTI = (FLUSH_CYC > 1) ? 1'b1 : 1'b0;

  state_t     state_r;
  state_t     state_nxt;
  logic [2:0] cnt_r;
  logic [2:0] cnt_nxt;
  logic       halted_r;
  ctrl_t      ctrl_s;
  decision_t  dec_s;
  logic       stall_inc_s;

  assign dec_s = run_decision(trap, redirect, dmem_req, dmem_ready, mc_start, ld_use,
                              if_valid, halt_req, state_r == ST_MWAIT,
                              state_r == ST_MCYC, FLUSH_MULTI);

  // next-state, flush-count and bank-control decode
  always_comb begin
    ctrl_s    = CTRL_FREEZE;
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    case (state_r)
      ST_RESET: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        ctrl_s    = dec_s.ctrl;
        state_nxt = dec_s.next;
        if (dec_s.load_cnt) cnt_nxt = FLUSH_LOAD;
        else                cnt_nxt = cnt_r;
      end
      ST_MWAIT: begin
        if (dmem_ready) begin
          ctrl_s    = dec_s.ctrl;
          state_nxt = dec_s.next;
          if (dec_s.load_cnt) cnt_nxt = FLUSH_LOAD;
          else                cnt_nxt = cnt_r;
        end else begin
          ctrl_s = CTRL_FREEZE;
        end
      end
      ST_MCYC: begin
        if (mc_done) begin
          ctrl_s    = dec_s.ctrl;
          state_nxt = dec_s.next;
          if (dec_s.load_cnt) cnt_nxt = FLUSH_LOAD;
          else                cnt_nxt = cnt_r;
        end else begin
          ctrl_s = CTRL_BUBBLE;
        end
      end
      ST_FLUSH: begin
        // redirect is deliberately not consulted here; only a trap restarts the window
        ctrl_s = CTRL_TRAP;
        if (trap) begin
          cnt_nxt   = FLUSH_LOAD;
          state_nxt = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
        end else if (cnt_r <= 3'd1) begin
          cnt_nxt   = 3'd0;
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt   = cnt_r - 3'd1;
          state_nxt = ST_FLUSH;
        end
      end
      ST_HALT: begin
        ctrl_s = CTRL_FREEZE;
        if (!halt_req) state_nxt = ST_RUN;
        else           state_nxt = ST_HALT;
      end
      default: begin
        ctrl_s    = CTRL_FREEZE;
        state_nxt = ST_RESET;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // state, flush count and halted flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_RESET;
      cnt_r    <= 3'd0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      cnt_r    <= cnt_nxt;
      halted_r <= (state_nxt == ST_HALT);
    end
  end

  assign stall_inc_s = !ctrl_s.pc_en && (state_r != ST_RESET) && (state_r != ST_HALT);

  sat_counter #(.CNTW(CNTW)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc_s),
    .count (stall_cnt)
  );

  assign pc_en    = ctrl_s.pc_en;
  assign fd_en    = ctrl_s.fd_en;
  assign fd_flush = ctrl_s.fd_flush;
  assign dw_en    = ctrl_s.dw_en;
  assign dw_flush = ctrl_s.dw_flush;
  assign halted   = halted_r;
  assign state    = state_r;

endmodule
